// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int BTN_DEBOUNCE_DEF = 1_000_000;   // 10 ms at 100 MHz
    localparam int BTN_LONG_DEF     = 100_000_000; // 1 s
    localparam int BTN_REPEAT_DEF   = 20_000_000;  // 200 ms

    // Counter width for a count range of 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for an asynchronous board input; both stages reset to 0.
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/btn_debounce_ctrl.sv
// Debounce FSM for one push-button: clean level plus press/release/long strobes.
// Optional auto-repeat strobe is built only when BTN_REPEAT_EN is defined.
module btn_debounce_ctrl
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEF,
    parameter int LONG_CYCLES     = BTN_LONG_DEF,
    parameter int REPEAT_CYCLES   = BTN_REPEAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int HW = cnt_width(LONG_CYCLES);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CYCLES - 2);

    logic btn_s;

    btn_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_raw),
        .q   (btn_s)
    );

    btn_state_t    state, state_nx;
    logic [DW-1:0] deb_cnt, deb_nx;
    logic [HW-1:0] hold_cnt, hold_nx;
    logic          long_fired, fired_nx;
    logic          level_nx, press_nx, release_nx, long_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            long_fired    <= 1'b0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            state         <= state_nx;
            deb_cnt       <= deb_nx;
            hold_cnt      <= hold_nx;
            long_fired    <= fired_nx;
            btn_level     <= level_nx;
            press_pulse   <= press_nx;
            release_pulse <= release_nx;
            long_pulse    <= long_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        deb_nx     = deb_cnt;
        hold_nx    = hold_cnt;
        fired_nx   = long_fired;
        level_nx   = btn_level;
        press_nx   = 1'b0;
        release_nx = 1'b0;
        long_nx    = 1'b0;

        case (state)
            IDLE: begin
                fired_nx = 1'b0;
                if (btn_s) begin
                    state_nx = PRESS_WAIT;
                    deb_nx   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_nx = IDLE;
                end else if (deb_cnt == DEB_MAX) begin
                    state_nx = HELD;
                    press_nx = 1'b1;
                    level_nx = 1'b1;
                    hold_nx  = '0;
                end else begin
                    deb_nx = deb_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_nx = RELEASE_WAIT;
                    deb_nx   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_nx = HELD;
                end else if (deb_cnt == DEB_MAX) begin
                    state_nx   = IDLE;
                    release_nx = 1'b1;
                    level_nx   = 1'b0;
                    fired_nx   = 1'b0;
                end else begin
                    deb_nx = deb_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Hold time keeps running through release bounces; a release on the
        // same edge as the long threshold suppresses the long strobe.
        if (state == HELD || state == RELEASE_WAIT) begin
            if (hold_cnt != HOLD_MAX)
                hold_nx = hold_cnt + 1'b1;
            if (hold_cnt == HOLD_PRE && !long_fired && !release_nx) begin
                long_nx  = 1'b1;
                fired_nx = 1'b1;
            end
        end
    end

`ifdef BTN_REPEAT_EN
    localparam int RW = cnt_width(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_cnt, rep_nx;
    logic          rep_pulse_nx;
    logic          repeat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt  <= '0;
            repeat_q <= 1'b0;
        end else begin
            rep_cnt  <= rep_nx;
            repeat_q <= rep_pulse_nx;
        end
    end

    // The first repeat coincides with the long strobe; later ones only
    // advance while the button is solidly held.
    always_comb begin
        rep_nx       = rep_cnt;
        rep_pulse_nx = 1'b0;
        if (long_nx) begin
            rep_nx       = '0;
            rep_pulse_nx = 1'b1;
        end else if (state == IDLE) begin
            rep_nx = '0;
        end else if (state == HELD && long_fired) begin
            if (rep_cnt == REP_MAX) begin
                rep_nx       = '0;
                rep_pulse_nx = 1'b1;
            end else begin
                rep_nx = rep_cnt + 1'b1;
            end
        end
    end

    assign repeat_pulse = repeat_q;
`else
    logic unused_repeat;
    assign unused_repeat = ^REPEAT_CYCLES;
    assign repeat_pulse  = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce_ctrl.sv
// Randomised bench for btn_debounce_ctrl against a run-length reference model.
module tb_btn_debounce_ctrl;

    localparam int D = 4;
    localparam int L = 16;
    localparam int R = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_raw = 1'b0;
    logic btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse;

    btn_debounce_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L),
        .REPEAT_CYCLES   (R)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_raw       (btn_raw),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int n_press = 0, n_rel = 0, n_long = 0;
    int last_press = -1, last_rel = -1, last_long = -1;
    int rep_edges[$];

    // Reference model: level flips once btn_s has disagreed with it for D+1
    // consecutive edges; long/repeat timed from the accepted press.
    bit m1, ms, lvl, fired;
    int run, age, rep;
    bit e_press, e_rel, e_long, e_rep;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m1 = 0; ms = 0; lvl = 0; fired = 0;
        run = 0; age = 0; rep = 0;
        e_press = 0; e_rel = 0; e_long = 0; e_rep = 0;
    endtask

    task automatic model_step();
        bit bs, was_lvl, solid;
        if (rst) begin
            model_reset();
            return;
        end
        bs = ms; ms = m1; m1 = btn_raw;
        e_press = 0; e_rel = 0; e_long = 0; e_rep = 0;
        was_lvl = lvl;
        solid   = lvl && (run == 0);
        run = (bs != lvl) ? run + 1 : 0;
        if (run == D + 1) begin
            run = 0;
            lvl = !lvl;
            if (lvl) begin
                e_press = 1; age = 0; fired = 0; rep = 0;
            end else begin
                e_rel = 1;
            end
        end
        if (was_lvl) begin
            age++;
            if (age == L - 1 && !fired && !e_rel) begin
                e_long = 1; fired = 1;
            end
        end
`ifdef BTN_REPEAT_EN
        if (e_long) begin
            e_rep = 1; rep = 0;
        end else if (solid && fired) begin
            rep++;
            if (rep == R) begin
                e_rep = 1; rep = 0;
            end
        end
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        chk("btn_level", btn_level, lvl);
        chk("press_pulse", press_pulse, e_press);
        chk("release_pulse", release_pulse, e_rel);
        chk("long_pulse", long_pulse, e_long);
        chk("repeat_pulse", repeat_pulse, e_rep);
        if (press_pulse)   begin n_press++; last_press = cyc; end
        if (release_pulse) begin n_rel++;   last_rel   = cyc; end
        if (long_pulse)    begin n_long++;  last_long  = cyc; end
        if (repeat_pulse)  rep_edges.push_back(cyc);
    endtask

    task automatic hold(input bit v, input int n);
        btn_raw = v;
        repeat (n) tick();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_level", btn_level, 0);
        chk("rst_press", press_pulse, 0);
        chk("rst_release", release_pulse, 0);
        chk("rst_long", long_pulse, 0);
        chk("rst_repeat", repeat_pulse, 0);
        model_reset();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int k, np, nr, nl;
        model_reset();
        tick();
        tick();
        chk("reset_level", btn_level, 0);
        chk("reset_press", press_pulse, 0);
        rst = 1'b0;
        hold(0, 4);

        // Clean press then release after 20 cycles.
        k = cyc + 1;
        hold(1, 20);
        chk("press_edge", last_press, k + 6);
        chk("press_count", n_press, 1);
        k = cyc + 1;
        hold(0, 12);
        chk("release_edge", last_rel, k + 6);
        chk("release_count", n_rel, 1);

        // Press bounce: 2 high, 1 low, 3 high, then low.
        np = n_press;
        hold(1, 2); hold(0, 1); hold(1, 3); hold(0, 12);
        chk("bounce_press", n_press, np);
        chk("bounce_level", btn_level, 0);

        // Release bounce inside HELD.
        np = n_press; nr = n_rel; nl = n_long;
        k = cyc + 1;
        hold(1, 10); hold(0, 2); hold(1, 18);
        chk("rb_level", btn_level, 1);
        chk("rb_release", n_rel, nr);
        chk("rb_long_edge", last_long, k + 21);
        chk("rb_long_count", n_long, nl + 1);
        hold(0, 12);

        // Long press held 40 cycles.
        nl = n_long;
        rep_edges.delete();
        k = cyc + 1;
        hold(1, 40);
        chk("long_edge", last_long, k + 21);
        chk("long_count", n_long, nl + 1);
        hold(0, 12);
`ifdef BTN_REPEAT_EN
        chk("repeat_count", rep_edges.size(), 3);
        if (rep_edges.size() == 3) begin
            chk("repeat_0", rep_edges[0], k + 21);
            chk("repeat_1", rep_edges[1], k + 29);
            chk("repeat_2", rep_edges[2], k + 37);
        end
`else
        chk("repeat_count", rep_edges.size(), 0);
`endif

        // Reset while HELD.
        np = n_press;
        hold(1, 14);
        chk("pre_rst_level", btn_level, 1);
        btn_raw = 1'b0;
        async_reset();
        hold(0, 10);
        chk("post_rst_press", n_press, np + 1);
        chk("post_rst_level", btn_level, 0);

        // Button held across reset gives a fresh press.
        btn_raw = 1'b1;
        tick(); tick(); tick();
        async_reset();
        k = cyc + 1;
        hold(1, 10);
        chk("held_rst_press", last_press, k + 6);
        hold(0, 12);

        // Random runs, mostly short with occasional long holds.
        for (int i = 0; i < 300; i++) begin
            int len;
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 45)
                                               : $urandom_range(1, 9);
            hold(1'($urandom_range(0, 1)), len);
            if ($urandom_range(0, 99) == 0) async_reset();
        end
        hold(0, 12);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
